// File: rtl/seq_wrap_checker.sv
// Sequence checker for an upstream wrapping counter (LOW..HIGH..LOW).
// Tracks the next required value, counts matched wraps and flags
// sequence and range violations until explicitly cleared.
module seq_wrap_checker #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] LOW   = WIDTH'(1),
  parameter logic [WIDTH-1:0] HIGH  = WIDTH'(10)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] expected,
  output logic [15:0]      wrap_count,
  output logic             mismatch,
  output logic             error,
  output logic             range_err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t           st;
  logic             in_range;
  logic             accept;
  logic [WIDTH-1:0] next_val;

  assign state = st;

  // Ready is decoded from state and reset only; in_data never reaches an output.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && (st != ERROR)) begin
      in_ready = 1'b1;
    end
  end

  // Beat classification; the +1 path is only taken when in_data < HIGH.
  always_comb begin
    in_range = (in_data >= LOW) && (in_data <= HIGH);
    accept   = in_valid && in_ready;
    next_val = (in_data == HIGH) ? LOW : (in_data + WIDTH'(1));
  end

  // Checker FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= IDLE;
      expected   <= LOW;
      wrap_count <= '0;
      mismatch   <= 1'b0;
      error      <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (st)
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              st       <= TRACK;
              expected <= next_val;
            end else begin
              st        <= ERROR;
              range_err <= 1'b1;
              error     <= 1'b1;
              mismatch  <= 1'b1;
            end
          end
        end
        TRACK: begin
          if (accept) begin
            if (in_data == expected) begin
              expected <= next_val;
              if ((in_data == HIGH) && (wrap_count != '1)) begin
                wrap_count <= wrap_count + 16'd1;
              end
            end else begin
              st       <= ERROR;
              error    <= 1'b1;
              mismatch <= 1'b1;
              if (!in_range) begin
                range_err <= 1'b1;
              end
            end
          end
        end
        ERROR: begin
          if (clear_err) begin
            st        <= IDLE;
            error     <= 1'b0;
            range_err <= 1'b0;
            expected  <= LOW;
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_wrap_checker.sv
// Self-checking bench for seq_wrap_checker: directed vector table,
// hand-written corner sequences and a randomized run against a
// behavioural model of the counter-following rules.
module tb_seq_wrap_checker;

  localparam int unsigned W  = 32;
  localparam logic [31:0] LO = 32'd1;
  localparam logic [31:0] HI = 32'd10;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        clear_err;
  logic [31:0] expected;
  logic [15:0] wrap_count;
  logic        mismatch;
  logic        error;
  logic        range_err;
  logic [1:0]  state;

  seq_wrap_checker #(.WIDTH(W), .LOW(LO), .HIGH(HI)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clear_err  (clear_err),
    .expected   (expected),
    .wrap_count (wrap_count),
    .mismatch   (mismatch),
    .error      (error),
    .range_err  (range_err),
    .state      (state)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Behavioural model: "synced" = a legal first value has been seen,
  // "faulted" = waiting for clear_err after a violation.
  bit          m_sync, m_fault, m_err, m_rerr, m_mm;
  logic [31:0] m_exp;
  int unsigned m_wc;

  function automatic logic [31:0] succ(input logic [31:0] d);
    return (d == HI) ? LO : d + 32'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_fault = 0; m_err = 0; m_rerr = 0; m_mm = 0;
    m_exp = LO; m_wc = 0;
  endtask

  // Applies the rules for one rising edge using the currently driven inputs.
  task automatic model_step();
    bit ok;
    if (reset) begin
      model_reset();
      return;
    end
    m_mm = 0;
    ok = (in_data >= LO) && (in_data <= HI);
    if (m_fault) begin
      if (clear_err) begin
        m_fault = 0; m_err = 0; m_rerr = 0; m_sync = 0; m_exp = LO;
      end
    end else if (in_valid) begin
      if (!m_sync) begin
        if (ok) begin
          m_sync = 1; m_exp = succ(in_data);
        end else begin
          m_fault = 1; m_err = 1; m_rerr = 1; m_mm = 1;
        end
      end else if (in_data == m_exp) begin
        if (in_data == HI && m_wc < 65535) m_wc++;
        m_exp = succ(in_data);
      end else begin
        m_fault = 1; m_err = 1; m_mm = 1;
        if (!ok) m_rerr = 1;
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [31:0] d, input bit c);
    reset = r; in_valid = v; in_data = d; clear_err = c;
  endtask

  // One model-checked cycle: called at a negedge, returns at the next negedge.
  task automatic cyc(input bit r, input bit v, input logic [31:0] d, input bit c);
    logic [1:0] mst;
    drive(r, v, d, c);
    #1 chk("in_ready_pre", {31'd0, in_ready}, {31'd0, (!r && !m_fault)});
    model_step();
    @(posedge clock);
    @(negedge clock);
    mst = m_fault ? 2'd2 : (m_sync ? 2'd1 : 2'd0);
    chk("state", {30'd0, state}, {30'd0, mst});
    chk("expected", expected, m_exp);
    chk("wrap_count", {16'd0, wrap_count}, m_wc);
    chk("mismatch", {31'd0, mismatch}, {31'd0, m_mm});
    chk("error", {31'd0, error}, {31'd0, m_err});
    chk("range_err", {31'd0, range_err}, {31'd0, m_rerr});
  endtask

  typedef struct {
    bit          r, v, c;
    logic [31:0] d;
    logic [1:0]  st;
    logic [31:0] ex;
    logic [15:0] wc;
    bit          mm, er, re, rdy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // r v c  d     st ex  wc mm er re rdy
    tbl[0]  = '{1, 0, 0, 32'd0,  2'd0, 32'd1,  16'd0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 32'd7,  2'd1, 32'd8,  16'd0, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 0, 32'd8,  2'd1, 32'd9,  16'd0, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 32'd9,  2'd1, 32'd10, 16'd0, 0, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 32'd10, 2'd1, 32'd1,  16'd1, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, 32'd1,  2'd1, 32'd2,  16'd1, 0, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 32'd0,  2'd0, 32'd1,  16'd0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 32'd3,  2'd1, 32'd4,  16'd0, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 32'd4,  2'd1, 32'd5,  16'd0, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 32'd6,  2'd2, 32'd5,  16'd0, 1, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 32'd5,  2'd2, 32'd5,  16'd0, 0, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 32'd0,  2'd0, 32'd1,  16'd0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 32'd11, 2'd2, 32'd1,  16'd0, 1, 1, 1, 0};
    tbl[13] = '{0, 0, 1, 32'd0,  2'd0, 32'd1,  16'd0, 0, 0, 0, 1};
    tbl[14] = '{0, 1, 0, 32'd10, 2'd1, 32'd1,  16'd0, 0, 0, 0, 1};
    tbl[15] = '{0, 1, 0, 32'd1,  2'd1, 32'd2,  16'd0, 0, 0, 0, 1};
    tbl[16] = '{1, 1, 1, 32'd5,  2'd0, 32'd1,  16'd0, 0, 0, 0, 0};

    drive(1, 0, 32'd0, 0);
    model_reset();
    @(negedge clock);

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      model_step();
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("tbl%0d.state", i), {30'd0, state}, {30'd0, tbl[i].st});
      chk($sformatf("tbl%0d.expected", i), expected, tbl[i].ex);
      chk($sformatf("tbl%0d.wrap_count", i), {16'd0, wrap_count}, {16'd0, tbl[i].wc});
      chk($sformatf("tbl%0d.mismatch", i), {31'd0, mismatch}, {31'd0, tbl[i].mm});
      chk($sformatf("tbl%0d.error", i), {31'd0, error}, {31'd0, tbl[i].er});
      chk($sformatf("tbl%0d.range_err", i), {31'd0, range_err}, {31'd0, tbl[i].re});
      chk($sformatf("tbl%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
    end

    // Two full wraps then one more beat.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 2; k++)
      for (int v = 1; v <= 10; v++) cyc(0, 1, v, 0);
    cyc(0, 1, 1, 0);
    chk("stream.state", {30'd0, state}, 32'd1);
    chk("stream.wrap_count", {16'd0, wrap_count}, 32'd2);
    chk("stream.expected", expected, 32'd2);
    chk("stream.error", {31'd0, error}, 32'd0);

    // Valid gaps, then reset dominating clear_err and in_valid.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 32'd7, 0);
    cyc(0, 1, 2, 0);
    cyc(0, 1, 3, 0);
    chk("gaps.expected", expected, 32'd4);
    chk("gaps.error", {31'd0, error}, 32'd0);
    cyc(1, 1, 5, 1);
    chk("rstdom.state", {30'd0, state}, 32'd0);
    chk("rstdom.expected", expected, 32'd1);

    // Saturation: preload the count near full, then two more wraps.
    for (int v = 1; v <= 10; v++) cyc(0, 1, v, 0);
    force dut.wrap_count = 16'hFFFE;
    m_wc = 32'hFFFE;
    cyc(0, 0, 0, 0);
    release dut.wrap_count;
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 2; k++)
      for (int v = 1; v <= 10; v++) cyc(0, 1, v, 0);
    chk("sat.wrap_count", {16'd0, wrap_count}, 32'h0000FFFF);
    cyc(0, 1, 1, 0);
    chk("sat.held", {16'd0, wrap_count}, 32'h0000FFFF);

    // Randomized run against the model.
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit          r, v, c;
      logic [31:0] d;
      int unsigned pick;
      r = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 19);
      if (pick < 16)      d = m_sync ? m_exp : $urandom_range(1, 10);
      else if (pick < 19) d = $urandom_range(0, 12);
      else                d = $urandom();
      cyc(r, v, d, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_wrap_checker.md
SEQ_WRAP_CHECKER -- requirements
Module: seq_wrap_checker

Interface
REQ-001 Parameter: WIDTH, default 32, data width of the incoming counter value.
REQ-002 Parameter: LOW, default 1, lowest legal counter value and restart value after wrap.
REQ-003 Parameter: HIGH, default 10, highest legal counter value; LOW < HIGH SHALL hold, and all comparisons SHALL be unsigned.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream counter presents a value this cycle.
REQ-007 in_data  input  WIDTH  counter value from the upstream wrapping counter.
REQ-008 in_ready  output  1  checker accepts a beat this cycle.
REQ-009 clear_err  input  1  request to leave ERROR and re-synchronise.
REQ-010 expected  output  WIDTH  next value the checker requires.
REQ-011 wrap_count  output  16  number of matched HIGH beats, saturating.
REQ-012 mismatch  output  1  one-cycle pulse for each rejected beat.
REQ-013 error  output  1  sticky flag for any sequence or range violation.
REQ-014 range_err  output  1  sticky flag for a beat outside [LOW, HIGH].
REQ-015 state  output  2  FSM state: IDLE=0, TRACK=1, ERROR=2; code 3 unused.

Function
REQ-016 A beat SHALL be accepted on a rising edge where in_valid && in_ready; no other edge SHALL change expected, wrap_count or flags, except clear_err and reset.
REQ-017 in_ready SHALL be 1 in IDLE and TRACK, 0 in ERROR, and 0 while reset is asserted, decoded combinationally from state and reset.
REQ-018 IDLE, accepted beat d with LOW<=d<=HIGH: go to TRACK; expected SHALL become LOW if d==HIGH, else d+1; wrap_count is unchanged.
REQ-019 IDLE, accepted beat d out of range: go to ERROR; set range_err and error; pulse mismatch.
REQ-020 TRACK, accepted d==expected: stay in TRACK; advance expected as in REQ-018.
REQ-021 TRACK, accepted d==expected and d==HIGH: wrap_count SHALL increment, saturating at 16'hFFFF.
REQ-022 TRACK, accepted d!=expected: go to ERROR; pulse mismatch; set error; set range_err as well if d is out of range; expected SHALL hold.
REQ-023 mismatch SHALL be high exactly in the cycle after the offending edge and low otherwise.
REQ-024 ERROR: no beats accepted; in_valid is ignored.
REQ-025 ERROR with clear_err=1 at an edge: next state is IDLE; error and range_err clear; expected becomes LOW; wrap_count is retained.
REQ-026 clear_err in IDLE or TRACK SHALL have no effect.
REQ-027 The increment d+1 SHALL be computed at WIDTH bits; since d<HIGH in that case, no overflow path SHALL exist.
REQ-028 The block SHALL contain no combinational path from in_data to any output.

Reset
REQ-029 reset SHALL dominate all other inputs, including clear_err and in_valid.
REQ-030 On reset, state SHALL be IDLE, expected LOW, wrap_count 0, and mismatch, error and range_err 0.
REQ-031 Reset asserted mid-sequence SHALL discard tracking, with the first beat after reset handled per REQ-018/019.

Verification
REQ-032 Stream 1,2,...,10,1,...,10,1 with valid every cycle -> state TRACK, wrap_count=2, expected=2, error=0, mismatch never high.
REQ-033 First beat 7, then 8,9,10,1 -> expected=2, wrap_count=1.
REQ-034 Sequence 3,4,6 -> mismatch high one cycle after 6 is accepted; state=ERROR, error=1, range_err=0, expected=5, in_ready=0; a following in_valid with 5 is not accepted.
REQ-035 First beat 11 -> ERROR, range_err=1; then clear_err pulse -> IDLE, flags=0, in_ready=1; beat 10 -> expected=1, wrap_count unchanged.
REQ-036 Valid gaps: 1, idle 3 cycles, 2, 3 -> no error, expected=4; reset asserted together with clear_err and in_valid=1, in_data=5 -> all outputs at reset values.
REQ-037 Force wrap_count to FFFF via 65535 wraps or a shortened-run test bench, then one further wrap -> wrap_count stays 16'hFFFF.
